// File: rtl/fsm_led3_stimulus.sv
// Closed-loop exerciser for the 3-switch / 3-LED Moore FSM: plays an 8-step
// switch sequence, samples the LEDs at the end of each hold window and scores them.
`timescale 1ns/1ps
module fsm_led3_stimulus #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] led,
  output logic [2:0] sw_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] fail_step,
  output logic [2:0] step
);

  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_DONE} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_next;
  logic [7:0] r_timer;
  logic [2:0] r_step;
  logic [2:0] r_sw_out;
  logic [2:0] r_fail_step;
  logic [3:0] r_err_cnt;
  logic       r_pass;
  logic       w_sample;
  logic       w_last;
  logic       w_mismatch;

  function automatic logic [2:0] code_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    code_rom = 3'b001;
      3'd1:    code_rom = 3'b010;
      3'd2:    code_rom = 3'b100;
      3'd3:    code_rom = 3'b011;
      3'd4:    code_rom = 3'b010;
      3'd5:    code_rom = 3'b100;
      3'd6:    code_rom = 3'b111;
      default: code_rom = 3'b000;
    endcase
  endfunction

  // LED pattern the FSM should show once the step's code has taken effect
  function automatic logic [2:0] exp_rom(input logic [2:0] idx);
    case (idx)
      3'd0:    exp_rom = 3'b001;
      3'd1:    exp_rom = 3'b010;
      3'd2:    exp_rom = 3'b100;
      3'd3:    exp_rom = 3'b001;
      3'd4:    exp_rom = 3'b010;
      3'd5:    exp_rom = 3'b100;
      3'd6:    exp_rom = 3'b111;
      default: exp_rom = 3'b000;
    endcase
  endfunction

  assign w_sample   = (r_state == ST_DRIVE) && (r_timer == HOLD_LAST);
  assign w_last     = w_sample && (r_step == 3'd7);
  assign w_mismatch = w_sample && (led != exp_rom(r_step));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_DRIVE;
      ST_DRIVE: if (w_last) w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == ST_DRIVE);
    done = (r_state == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer     <= 8'd0;
      r_step      <= 3'd0;
      r_sw_out    <= 3'd0;
      r_fail_step <= 3'd0;
      r_err_cnt   <= 4'd0;
      r_pass      <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_timer     <= 8'd0;
      r_step      <= 3'd0;
      r_sw_out    <= code_rom(3'd0);
      r_fail_step <= 3'd0;
      r_err_cnt   <= 4'd0;
      r_pass      <= 1'b0;
    end else if (r_state == ST_DRIVE) begin
      if (w_sample) begin
        r_timer <= 8'd0;
        if (w_mismatch) begin
          r_err_cnt <= r_err_cnt + 4'd1;
          if (r_err_cnt == 4'd0) r_fail_step <= r_step;
        end
        // Final compare folds into pass so it is already valid in the done cycle
        if (w_last) begin
          r_sw_out <= 3'd0;
          r_pass   <= (r_err_cnt == 4'd0) && !w_mismatch;
        end else begin
          r_step   <= r_step + 3'd1;
          r_sw_out <= code_rom(r_step + 3'd1);
        end
      end else begin
        r_timer <= r_timer + 8'd1;
      end
    end
  end

  assign sw_out    = r_sw_out;
  assign pass      = r_pass;
  assign err_cnt   = r_err_cnt;
  assign fail_step = r_fail_step;
  assign step      = r_step;

endmodule

// File: doc/fsm_led3_stimulus.md
# fsm_led3_stimulus

Closed-loop board-level exerciser for the 3-switch / 3-LED Moore LED FSM. On a start request it drives a fixed 8-step code sequence onto the FSM's `sw` inputs, holding each code for a programmable number of cycles. At the end of each hold window it samples the FSM's `led` outputs and compares them with the expected pattern. It reports mismatches and a pass flag, so the LED FSM can be checked on hardware without hand-toggling switches.

## Interface

Parameters:

- `HOLD_CYCLES`, default 4: cycles each code is held on `sw_out`. Legal range is 3..255; the compare needs 2 cycles of FSM latency.

Ports:

- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `start`  input  1  single-cycle run request; honoured only in IDLE.
- `led`  input  3  LED outputs of the FSM under test.
- `sw_out`  output  3  registered switch code, wired to the FSM `sw`.
- `busy`  output  1  high in DRIVE.
- `done`  output  1  one-cycle pulse on run completion.
- `pass`  output  1  high when the last completed run had zero mismatches; holds until the next start.
- `err_cnt`  output  4  mismatch count of the current or last run (0..8).
- `fail_step`  output  3  step index of the first mismatch; valid when `err_cnt` != 0.
- `step`  output  3  current step index.

## Operation

- Code ROM, steps 0..7:
  - `sw` codes: 001, 010, 100, 011, 010, 100, 111, 000.
  - FSM path: S0→S1→S2→S3→S1→S2→S3→S4→S0.
- Expected-LED ROM, steps 0..7: 001, 010, 100, 001, 010, 100, 111, 000.
- The sequence ends in S0, so back-to-back runs need no FSM reset. The FSM must start in S0 with `led` = 000.
- 8-bit hold timer; `step` is the 3-bit ROM index.

States:

- IDLE
  - Outputs: `sw_out` = 000, `busy` = 0.
  - On `start` = 1:
    - Go to DRIVE.
    - Set `step` = 0, timer = 0, `sw_out` = ROM[0].
    - Clear `err_cnt`, `fail_step` and `pass`.
- DRIVE
  - Increment the timer each cycle.
  - When timer == `HOLD_CYCLES`−1, compare `led` with EXP[`step`]:
    - On mismatch, increment `err_cnt`.
    - On the first mismatch (`err_cnt` == 0 before the increment), latch `fail_step` = `step`.
  - Same cycle, if `step` < 7:
    - Increment `step` and clear the timer.
    - Set `sw_out` = ROM[`step`+1].
  - Same cycle, if `step` == 7: go to DONE.
- DONE
  - Outputs: `done` = 1, `sw_out` = 000, `pass` = (`err_cnt` == 0), `busy` = 0.
  - Unconditionally go to IDLE next cycle.
  - `start` asserted in DONE is ignored.

Rules:

- `start` in DRIVE or DONE is ignored and never restarts the run.
- `err_cnt` cannot exceed 8, so it is not saturated. The final-cycle compare and increment must land before DONE.
- Reset at any time, including mid-run:
  - State goes to IDLE.
  - `sw_out` = 000.
  - `step`, timer, `err_cnt`, `fail_step` = 0.
  - `busy`, `done`, `pass` = 0.
- Reset wins over a simultaneous `start`.

## Timing

- Reset values of all outputs are 0.
- `start` sampled high at edge t:
  - `busy` = 1 and `sw_out` = 001 from t+1.
  - The step k code is visible over cycles t+1+k·H .. t+(k+1)·H, where H = `HOLD_CYCLES`.
- FSM latency is 2 cycles (state register, then LED register). `led` reflects step k's code by cycle t+1+k·H+2, which is no later than the sample cycle t+(k+1)·H when H ≥ 3.
- The step 7 sample is at cycle t+8·H. `done` pulses at t+8·H+1, and the block is back in IDLE at t+8·H+2.
- With H = 4: `done` at t+33; earliest next accepted `start` at t+34.
- `pass`, `err_cnt` and `fail_step` are stable from the `done` cycle until the next accepted `start`.

## Test plan

- Ideal LED FSM model, H = 4:
  - Pulse `start`.
  - Required: `sw_out` sequence 001, 010, 100, 011, 010, 100, 111, 000, each held 4 cycles.
  - Required: `done` at t+33, `pass` = 1, `err_cnt` = 0.
- `led` forced to 000:
  - Required: `err_cnt` = 7 (step 7 matches), `fail_step` = 0, `pass` = 0.
- Fault injection: `led` bit 2 stuck at 0.
  - Failing steps are 2, 5 and 6.
  - Required: `err_cnt` = 3, `fail_step` = 2.
- Robustness of `start`:
  - `start` re-pulsed at t+10 and held during DONE: no restart; `done` still at t+33.
  - Two runs back-to-back with no FSM reset: both report `pass` = 1.
- Reset at t+15:
  - Required next cycle: `sw_out` = 000, `busy` = 0, `err_cnt` = 0, `step` = 0.
  - After resetting the FSM, a fresh `start` passes.
- H = 3 boundary:
  - Ideal model: `pass` = 1, `done` at t+25.
  - Model with 3-cycle latency: `err_cnt` = 8, `fail_step` = 0.
